// File: rtl/date_counter.sv
// Registered calendar date that advances one day per tick and accepts range-checked loads.
// Feeds dayOfYrCalc directly, so the outputs must always hold a valid date.
module date_counter #(
  parameter int CALENDER    = 0,
  parameter int RESET_DAY   = 1,
  parameter int RESET_MONTH = 1,
  parameter int RESET_YEAR  = 1970
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [5:0]  loadDay,
  input  logic [3:0]  loadMonth,
  input  logic [10:0] loadYear,
  output logic [5:0]  dayOfMonth,
  output logic [3:0]  month,
  output logic [10:0] year,
  output logic        newYear,
  output logic        yearWrap,
  output logic        loadErr
);

  // Constant-divisor remainders keep the leap test single-cycle combinational.
  function automatic logic is_leap(input logic [10:0] y);
    if (CALENDER == 1) return (y[1:0] == 2'b00);
    return (y[1:0] == 2'b00) && (((y % 11'd100) != 11'd0) || ((y % 11'd400) == 11'd0));
  endfunction

  function automatic logic [5:0] days_in_month(input logic [3:0] m, input logic [10:0] y);
    logic [5:0] dim;
    case (m)
      4'd2:                      dim = is_leap(y) ? 6'd29 : 6'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim = 6'd30;
      default:                   dim = 6'd31;
    endcase
    return dim;
  endfunction

  localparam logic [3:0]  RST_M = 4'(RESET_MONTH);
  localparam logic [10:0] RST_Y = 11'(RESET_YEAR);
  localparam logic [5:0]  RST_D = 6'(RESET_DAY);
  localparam bit RESET_VALID = (RESET_YEAR >= 0) && (RESET_YEAR <= 2047) &&
                               (RESET_MONTH >= 1) && (RESET_MONTH <= 12) &&
                               (RESET_DAY >= 1) &&
                               (RESET_DAY <= int'(days_in_month(RST_M, RST_Y)));

  if (!RESET_VALID) begin : g_bad_reset_date
    $error("date_counter: RESET_DAY/RESET_MONTH/RESET_YEAR is not a valid date");
  end

  logic [5:0]  day_n;
  logic [3:0]  month_n;
  logic [10:0] year_n;
  logic        new_year_n;
  logic        year_wrap_n;
  logic        load_err_n;
  logic [5:0]  cur_dim;
  logic [5:0]  load_dim;
  logic        load_ok;

  assign cur_dim  = days_in_month(month, year);
  assign load_dim = days_in_month(loadMonth, loadYear);
  assign load_ok  = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) &&
                    (loadDay >= 6'd1) && (loadDay <= load_dim);

  // Load wins over tick; a rejected load holds the date and only raises loadErr.
  always_comb begin
    day_n       = dayOfMonth;
    month_n     = month;
    year_n      = year;
    new_year_n  = 1'b0;
    year_wrap_n = 1'b0;
    load_err_n  = 1'b0;
    if (load) begin
      if (load_ok) begin
        day_n   = loadDay;
        month_n = loadMonth;
        year_n  = loadYear;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (tick) begin
      if (dayOfMonth < cur_dim) begin
        day_n = dayOfMonth + 6'd1;
      end else if (month < 4'd12) begin
        day_n   = 6'd1;
        month_n = month + 4'd1;
      end else begin
        day_n       = 6'd1;
        month_n     = 4'd1;
        year_n      = year + 11'd1;
        new_year_n  = 1'b1;
        year_wrap_n = (year == 11'd2047);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dayOfMonth <= RST_D;
      month      <= RST_M;
      year       <= RST_Y;
      newYear    <= 1'b0;
      yearWrap   <= 1'b0;
      loadErr    <= 1'b0;
    end else begin
      dayOfMonth <= day_n;
      month      <= month_n;
      year       <= year_n;
      newYear    <= new_year_n;
      yearWrap   <= year_wrap_n;
      loadErr    <= load_err_n;
    end
  end

endmodule

// File: tb/tb_date_counter.sv
// Drives a Gregorian and a Julian date_counter in lockstep and compares both
// against a calendar model built from month-length tables and plain arithmetic.
module tb_date_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [5:0]  loadDay = 6'd0;
  logic [3:0]  loadMonth = 4'd0;
  logic [10:0] loadYear = 11'd0;

  logic [5:0]  g_day, j_day;
  logic [3:0]  g_month, j_month;
  logic [10:0] g_year, j_year;
  logic        g_newYear, g_yearWrap, g_loadErr;
  logic        j_newYear, j_yearWrap, j_loadErr;

  int checks = 0;
  int errors = 0;

  int  gd, gm, gy, jd, jm, jy;
  bit  gny, gyw, gle, jny, jyw, jle;

  always #5 clk = ~clk;

  date_counter #(.CALENDER(0)) dut_greg (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .loadDay(loadDay), .loadMonth(loadMonth), .loadYear(loadYear),
    .dayOfMonth(g_day), .month(g_month), .year(g_year),
    .newYear(g_newYear), .yearWrap(g_yearWrap), .loadErr(g_loadErr)
  );

  date_counter #(.CALENDER(1)) dut_jul (
    .clk(clk), .reset(reset), .tick(tick), .load(load),
    .loadDay(loadDay), .loadMonth(loadMonth), .loadYear(loadYear),
    .dayOfMonth(j_day), .month(j_month), .year(j_year),
    .newYear(j_newYear), .yearWrap(j_yearWrap), .loadErr(j_loadErr)
  );

  logic [47:0] got_all;
  assign got_all = {g_day, g_month, g_year, g_newYear, g_yearWrap, g_loadErr,
                    j_day, j_month, j_year, j_newYear, j_yearWrap, j_loadErr};

  function automatic int mdays(input int m, input int y, input int cal);
    int tbl [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    bit leap;
    leap = (cal == 1) ? (y % 4 == 0) : ((y % 4 == 0 && y % 100 != 0) || y % 400 == 0);
    if (m == 2 && leap) return 29;
    return tbl[m-1];
  endfunction

  task automatic model_update(input int cal, input bit rst, input bit t, input bit l,
                              input int ld, input int lm, input int ly,
                              inout int d, inout int m, inout int y,
                              inout bit ny, inout bit yw, inout bit le);
    ny = 0; yw = 0; le = 0;
    if (rst) begin
      d = 1; m = 1; y = 1970;
    end else if (l) begin
      if (lm >= 1 && lm <= 12 && ld >= 1 && ld <= mdays(lm, ly, cal)) begin
        d = ld; m = lm; y = ly;
      end else le = 1;
    end else if (t) begin
      d++;
      if (d > mdays(m, y, cal)) begin
        d = 1; m++;
        if (m > 12) begin
          m = 1; y++; ny = 1;
          if (y > 2047) begin y = 0; yw = 1; end
        end
      end
    end
  endtask

  function automatic logic [23:0] pack(input int d, input int m, input int y,
                                       input bit ny, input bit yw, input bit le);
    return {6'(d), 4'(m), 11'(y), ny, yw, le};
  endfunction

  function automatic logic [47:0] expected_all();
    return {pack(gd, gm, gy, gny, gyw, gle), pack(jd, jm, jy, jny, jyw, jle)};
  endfunction

  task automatic drive_step(input bit rst, input bit t, input bit l,
                            input int ld, input int lm, input int ly);
    @(negedge clk);
    reset = rst; tick = t; load = l;
    loadDay = 6'(ld); loadMonth = 4'(lm); loadYear = 11'(ly);
    @(posedge clk);
    model_update(0, rst, t, l, ld, lm, ly, gd, gm, gy, gny, gyw, gle);
    model_update(1, rst, t, l, ld, lm, ly, jd, jm, jy, jny, jyw, jle);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive_step(1, 1, 0, 0, 0, 0);
      checks++;
      if (got_all !== expected_all() || got_all[23:0] !== pack(1, 1, 1970, 0, 0, 0)) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d got %h expected %h", i, got_all, expected_all());
      end
    end
  endtask

  task automatic test_leap();
    int seq [8][4] = '{'{1, 28, 2, 1900}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                       '{1, 28, 2, 2000}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                       '{1, 29, 2, 2004}, '{0, 0, 0, 0}};
    for (int i = 0; i < 8; i++) begin
      drive_step(0, seq[i][0] == 0, seq[i][0] == 1, seq[i][1], seq[i][2], seq[i][3]);
      checks++;
      if (got_all !== expected_all()) begin
        errors++;
        $display("[TB] FAIL leap step %0d got %h expected %h", i, got_all, expected_all());
      end
    end
    checks++;
    if (g_day !== 6'd1 || g_month !== 4'd3 || j_day !== 6'd1 || j_month !== 4'd3) begin
      errors++;
      $display("[TB] FAIL leap_2004_end got %0d/%0d and %0d/%0d expected 1/3", g_day, g_month, j_day, j_month);
    end
  endtask

  task automatic test_rollover();
    int seq [6][4] = '{'{1, 31, 12, 1999}, '{0, 0, 0, 0}, '{2, 0, 0, 0},
                       '{1, 31, 12, 2047}, '{0, 0, 0, 0}, '{2, 0, 0, 0}};
    for (int i = 0; i < 6; i++) begin
      drive_step(0, seq[i][0] == 0, seq[i][0] == 1, seq[i][1], seq[i][2], seq[i][3]);
      checks++;
      if (got_all !== expected_all()) begin
        errors++;
        $display("[TB] FAIL rollover step %0d got %h expected %h", i, got_all, expected_all());
      end
      if (i == 4) begin
        checks++;
        if (got_all[23:0] !== pack(1, 1, 0, 1, 1, 0)) begin
          errors++;
          $display("[TB] FAIL year_wrap got %h expected %h", got_all[23:0], pack(1, 1, 0, 1, 1, 0));
        end
      end
    end
  endtask

  task automatic test_invalid_load();
    int seq [9][3] = '{'{10, 6, 2016}, '{31, 4, 2016}, '{0, 0, 0}, '{29, 2, 1971},
                       '{0, 0, 0}, '{0, 6, 2000}, '{8, 14, 1980}, '{0, 0, 0}, '{29, 2, 1900}};
    for (int i = 0; i < 9; i++) begin
      drive_step(0, 0, seq[i][0] != 0 || seq[i][1] != 0, seq[i][0], seq[i][1], seq[i][2]);
      checks++;
      if (got_all !== expected_all()) begin
        errors++;
        $display("[TB] FAIL invalid_load step %0d got %h expected %h", i, got_all, expected_all());
      end
    end
  endtask

  task automatic test_priority();
    drive_step(0, 1, 1, 10, 6, 2016);
    checks++;
    if (got_all !== expected_all() || got_all[23:3] !== 21'({6'd10, 4'd6, 11'd2016})) begin
      errors++;
      $display("[TB] FAIL load_over_tick got %h expected %h", got_all, expected_all());
    end
    drive_step(0, 1, 0, 0, 0, 0);
    checks++;
    if (got_all !== expected_all()) begin
      errors++;
      $display("[TB] FAIL tick_after_load got %h expected %h", got_all, expected_all());
    end
    drive_step(1, 1, 1, 20, 7, 2020);
    checks++;
    if (got_all !== expected_all()) begin
      errors++;
      $display("[TB] FAIL reset_over_load got %h expected %h", got_all, expected_all());
    end
  endtask

  task automatic test_continuous();
    int pulses = 0;
    drive_step(0, 0, 1, 1, 1, 2016);
    for (int k = 1; k <= 366; k++) begin
      drive_step(0, 1, 0, 0, 0, 0);
      pulses += int'(g_newYear);
      checks++;
      if (got_all !== expected_all()) begin
        errors++;
        $display("[TB] FAIL continuous tick %0d got %h expected %h", k, got_all, expected_all());
      end
      if (k == 59 || k == 365) begin
        checks++;
        if (got_all[23:3] !== ((k == 59) ? 21'({6'd29, 4'd2, 11'd2016}) : 21'({6'd31, 4'd12, 11'd2016}))) begin
          errors++;
          $display("[TB] FAIL day_of_year_%0d got %0d/%0d/%0d", k + 1, g_day, g_month, g_year);
        end
      end
    end
    drive_step(0, 0, 0, 0, 0, 0);
    checks++;
    if (pulses != 1 || g_day !== 6'd1 || g_month !== 4'd1 || g_year !== 11'd2017 || g_newYear !== 1'b0) begin
      errors++;
      $display("[TB] FAIL continuous_end pulses %0d date %0d/%0d/%0d expected 1 pulse 1/1/2017", pulses, g_day, g_month, g_year);
    end
  endtask

  task automatic test_random();
    int years [6] = '{0, 100, 1900, 2000, 2047, 1996};
    int ly;
    for (int i = 0; i < 400; i++) begin
      ly = ($urandom_range(0, 1) == 0) ? years[$urandom_range(0, 5)] : int'($urandom_range(0, 2047));
      drive_step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), ly);
      checks++;
      if (got_all !== expected_all()) begin
        errors++;
        $display("[TB] FAIL random step %0d got %h expected %h", i, got_all, expected_all());
      end
    end
  endtask

  initial begin
    gd = 0; gm = 0; gy = 0; gny = 0; gyw = 0; gle = 0;
    jd = 0; jm = 0; jy = 0; jny = 0; jyw = 0; jle = 0;
    test_reset();
    test_leap();
    test_rollover();
    test_invalid_load();
    test_priority();
    test_continuous();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
